fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of rom_controller.
- Generates sequential word fetches on the rom_req/rom_addr interface and captures rom_rdata on rom_ready.
- Buffers fetched words in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Supports PC redirect (branch/jump) and yields the ROM while MBIST runs.

Parameters:
- ADDR_W, 15, ROM byte-address width (matches rom_addr).
- DATA_W, 32, instruction word width.
- FIFO_DEPTH, 4, prefetch buffer entries (power of two, ≥2).
- RESET_PC, 15'h0000, first fetch byte address after reset (word aligned).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rom_req  out  1  fetch request to rom_controller, one cycle per word
- rom_addr  out  ADDR_W  byte address of request; bits[1:0] always 0
- rom_rdata  in  DATA_W  fetched word
- rom_ready  in  1  response valid; expected exactly 1 cycle after rom_req
- mbist_en  in  1  MBIST owns ROM; fetch suspended
- redirect_valid  in  1  load new PC this cycle
- redirect_pc  in  ADDR_W  redirect target; bits[1:0] ignored (forced 0)
- instr_valid  out  1  instr_data/instr_pc valid to decode
- instr_ready  in  1  decode accepts word
- instr_data  out  DATA_W  instruction word
- instr_pc  out  ADDR_W  byte address of instr_data
- fetch_err  out  1  sticky: in-flight request got no rom_ready next cycle

Behaviour:
- Reset values: rom_req=0, rom_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, fetch_err=0, FIFO empty, fetch_pc=RESET_PC, state=IDLE.
- FSM states:
  - IDLE: one cycle after reset release, then RUN.
  - RUN: issues fetches.
  - HOLD: entered when mbist_en=1; returns to RUN on the first cycle mbist_en=0.
  - mbist_en=1 in any state forces HOLD.
- Issue rule (RUN only): rom_req=1 iff fifo_count + inflight < FIFO_DEPTH and no redirect this cycle.
  - rom_addr=fetch_pc.
  - fetch_pc += 4, modulo 2^ADDR_W (0x7FFC wraps to 0x0000).
  - Back-to-back issue every cycle is allowed.
- Response: the inflight flag is set in the cycle after rom_req.
  - inflight and rom_ready=1: push {rom_rdata, pc} into the FIFO, unless the entry is marked discard.
  - inflight and rom_ready=0: set fetch_err (sticky until rst) and drop the entry.
- Output:
  - instr_valid = FIFO not empty; head drives instr_data/instr_pc combinationally from registered storage.
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including when full (count unchanged).
- Latency: with an empty FIFO and instr_ready=1, first instr_valid occurs 2 cycles after rom_req.
- Redirect (redirect_valid=1):
  - Next cycle the FIFO is empty, fetch_pc=redirect_pc&~3, and any in-flight response is marked discard.
  - A handshake completing in the redirect cycle counts as accepted.
  - No rom_req in the redirect cycle; the first new request follows on the next cycle.
  - Redirect has priority over issue and push.
- MBIST entry (mbist_en rises):
  - rom_req=0 immediately (combinational gate).
  - FIFO flushed, in-flight marked discard.
  - fetch_pc rewinds to next_deliver_pc, the pc of the oldest undelivered word (head pc, else in-flight pc, else fetch_pc).
  - instr_valid=0 during HOLD. redirect_valid during HOLD updates fetch_pc only.
- Reset mid-operation: all state returns to reset values asynchronously; outstanding ROM responses are ignored.
- Invariant: fifo_count + inflight ≤ FIFO_DEPTH, so the FIFO never overflows.

Decomposition:
- fetch_pkg: fetch_state_t enum {IDLE, RUN, HOLD}; WORD_BYTES=4; fetch_entry_t struct {data[DATA_W], pc[ADDR_W]}.
- Sub-module fetch_fifo: parameterized synchronous FIFO of fetch_entry_t with push/pop/flush, count, full/empty.
- fetch_unit holds the FSM, PC, inflight/discard tracking and the error flag.

Test Plan:
- Bench setup: behavioural ROM model with 1-cycle latency, word i = 0xDEAD0000+i.
- Reset, instr_ready=1 → rom_addr sequence 0x0000, 0x0004, 0x0008…; instr stream DEAD0000/pc 0x0000, DEAD0001/pc 0x0004, first instr_valid 2 cycles after first rom_req.
- instr_ready=0 for 10 cycles → exactly 4 rom_req issued, FIFO holds DEAD0000..DEAD0003, rom_req stays 0; release → order preserved, next rom_addr 0x0010.
- Redirect to 0x0102 while request to 0x0008 in flight → next delivered word DEAD0040 with instr_pc 0x0100; DEAD0002 never appears.
- mbist_en=1 after DEAD0000..0001 consumed and 2 words buffered → rom_req=0 and instr_valid=0 throughout HOLD; after mbist_en=0 the first rom_addr is 0x0008 and the stream resumes at DEAD0002.
- Redirect to 0x7FF8 → rom_addr 0x7FF8, 0x7FFC, 0x0000 (wrap); the ROM model's rom_ready is suppressed once → fetch_err=1 and stays 1 until rst.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM encoding and the
// prefetch FIFO entry layout (instruction word plus its byte address).
package fetch_pkg;

  localparam int WORD_BYTES   = 4;
  localparam int FETCH_ADDR_W = 15;
  localparam int FETCH_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] data;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: ROM request/response side, decode valid/ready side and the
// MBIST/redirect controls. master = fetch unit, slave = its environment.
interface fetch_unit_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);

  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rdata;
  logic              rom_ready;
  logic              mbist_en;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              fetch_err;

  modport master (
    output rom_req, rom_addr, instr_valid, instr_data, instr_pc, fetch_err,
    input  rom_rdata, rom_ready, mbist_en, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  rom_req, rom_addr, instr_valid, instr_data, instr_pc, fetch_err,
    output rom_rdata, rom_ready, mbist_en, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: push data lands one cycle later, head is read straight from storage;
// push+pop together is legal at any occupancy, flush empties it next cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type T     = fetch_entry_t,
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  T                 push_dat,
  input  logic             pop,
  input  logic             flush,
  output T                 head_dat,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_dat;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential word fetches to the ROM, 2 cycles from rom_req to instr_valid.
// Issue is throttled so buffered + in-flight words never exceed the FIFO; decode stalls via instr_ready.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = FETCH_ADDR_W,
  parameter int                DATA_W     = FETCH_DATA_W,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  localparam int                CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic [ADDR_W-1:0] next_deliver_pc;
  logic              inflight_q;
  logic              err_q;

  logic              mbist_entry;
  logic              issue;
  logic              has_room;
  logic              instr_vld;
  logic              push;
  logic              pop;
  logic              flush;

  entry_t            push_dat;
  entry_t            head_dat;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  fetch_fifo #(
    .T     (entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (flush),
    .head_dat (head_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign push_dat.data = bus.rom_rdata;
  assign push_dat.pc   = inflight_pc_q;

  // A word in flight will occupy a slot next cycle, so reserve it now.
  assign has_room = inflight_q ? (fifo_count < CNT_W'(FIFO_DEPTH - 1)) : !fifo_full;

  // Oldest word decode has not yet taken; MBIST entry rewinds here so nothing is lost.
  assign next_deliver_pc = !fifo_empty ? head_dat.pc :
                           inflight_q  ? inflight_pc_q : fetch_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.mbist_en) begin
      state_d = HOLD;
    end else begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = RUN;
        HOLD:    state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mbist_entry = bus.mbist_en && (state_q != HOLD);
    issue       = (state_q == RUN) && !bus.mbist_en && !bus.redirect_valid && has_room;
    instr_vld   = !fifo_empty && !bus.mbist_en;
    pop         = instr_vld && bus.instr_ready;
    // redirect or MBIST discards whatever response lands this cycle
    push        = inflight_q && bus.rom_ready && !bus.redirect_valid && !bus.mbist_en;
    flush       = bus.redirect_valid || mbist_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      err_q         <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) inflight_pc_q <= fetch_pc_q;
      if (inflight_q && !bus.rom_ready) err_q <= 1'b1;

      if (bus.redirect_valid)  fetch_pc_q <= bus.redirect_pc & ALIGN_MASK;
      else if (mbist_entry)    fetch_pc_q <= next_deliver_pc;
      else if (issue)          fetch_pc_q <= fetch_pc_q + ADDR_W'(WORD_BYTES);
    end
  end

  assign bus.rom_req     = issue;
  assign bus.rom_addr    = fetch_pc_q;
  assign bus.instr_valid = instr_vld;
  assign bus.instr_data  = head_dat.data;
  assign bus.instr_pc    = head_dat.pc;
  assign bus.fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: 1-cycle ROM model (word i = DEAD0000+i), program-order stream model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_unit #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (15'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    n_tests++;
    if (act > lim) begin
      n_fail++;
      $display("FAIL %s: got %0d, limit %0d (cycle %0d)", name, act, lim, cyc);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
    return 32'hDEAD0000 + 32'(a >> 2);
  endfunction

  // ROM model: request seen mid-cycle, response in the following cycle
  logic              pend_req = 1'b0;
  logic [ADDR_W-1:0] pend_addr = '0;
  logic              suppress_en = 1'b0;
  logic [ADDR_W-1:0] suppress_addr = '0;
  logic              suppress_done = 1'b0;
  logic              dropped_now = 1'b0;

  always @(negedge clk) begin
    pend_req  = bus.rom_req;
    pend_addr = bus.rom_addr;
  end

  always @(posedge clk) begin
    #1;
    dropped_now   = 1'b0;
    if (rst) suppress_done = 1'b0;
    bus.rom_rdata = rom_word(pend_addr);
    bus.rom_ready = pend_req;
    if (pend_req && suppress_en && !suppress_done && pend_addr == suppress_addr) begin
      bus.rom_ready = 1'b0;
      suppress_done = 1'b1;
      dropped_now   = 1'b1;
    end
  end

  // Program-order model: delivered words follow model_pc, requests follow req_pc.
  logic              skip_vld = 1'b0;
  logic [ADDR_W-1:0] skip_pc = '0;
  logic [ADDR_W-1:0] model_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              skip_done;
  logic              err_exp;
  logic              mbist_prev;
  logic [ADDR_W-1:0] req_log [$];
  logic [ADDR_W-1:0] pc_log [$];
  logic [31:0]       dat_log [$];
  int                first_req_cyc;
  int                first_vld_cyc;

  always @(negedge clk) begin
    if (rst) begin
      model_pc      = '0;
      req_pc        = '0;
      skip_done     = 1'b0;
      err_exp       = 1'b0;
      mbist_prev    = 1'b0;
      first_req_cyc = -1;
      first_vld_cyc = -1;
      req_log.delete();
      pc_log.delete();
      dat_log.delete();
    end else begin
      check("fetch_err", 32'(bus.fetch_err), 32'(err_exp));
      if (bus.mbist_en) begin
        check("hold_rom_req", 32'(bus.rom_req), 0);
        check("hold_instr_valid", 32'(bus.instr_valid), 0);
      end
      if (bus.redirect_valid) check("redirect_cycle_rom_req", 32'(bus.rom_req), 0);
      if (bus.instr_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (bus.instr_valid && bus.instr_ready) begin
        if (skip_vld && !skip_done && model_pc == skip_pc) begin
          model_pc  = model_pc + 15'd4;
          skip_done = 1'b1;
        end
        check("instr_pc", 32'(bus.instr_pc), 32'(model_pc));
        check("instr_data", bus.instr_data, rom_word(model_pc));
        pc_log.push_back(bus.instr_pc);
        dat_log.push_back(bus.instr_data);
        model_pc = model_pc + 15'd4;
      end
      if (bus.rom_req) begin
        if (first_req_cyc < 0) first_req_cyc = cyc;
        check("rom_addr", 32'(bus.rom_addr), 32'(req_pc));
        req_log.push_back(bus.rom_addr);
        req_pc = req_pc + 15'd4;
      end
      if (bus.redirect_valid) begin
        model_pc = bus.redirect_pc & ~15'h3;
        req_pc   = model_pc;
      end else if (bus.mbist_en && !mbist_prev) begin
        req_pc = model_pc;
      end
      mbist_prev = bus.mbist_en;
      check_le("words_outstanding", int'(15'(req_pc - model_pc) >> 2),
               DEPTH + ((skip_vld && !skip_done) ? 1 : 0));
      if (dropped_now) err_exp = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic rdy);
    @(posedge clk);
    #1;
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.mbist_en       = 1'b0;
    bus.instr_ready    = rdy;
    skip_vld           = 1'b0;
    suppress_en        = 1'b0;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic wait_req(input logic [ADDR_W-1:0] addr, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.rom_req && bus.rom_addr == addr) return;
    end
    check("wait_req_timeout", 0, 1);
  endtask

  task automatic wait_handshake(input logic [ADDR_W-1:0] pc, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.instr_valid && bus.instr_ready && bus.instr_pc == pc) return;
    end
    check("wait_handshake_timeout", 0, 1);
  endtask

  initial begin
    int idx;
    int found;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.mbist_en       = 1'b0;
    bus.instr_ready    = 1'b1;
    tick(2);

    check("rst_rom_req", 32'(bus.rom_req), 0);
    check("rst_rom_addr", 32'(bus.rom_addr), 0);
    check("rst_instr_valid", 32'(bus.instr_valid), 0);
    check("rst_instr_data", bus.instr_data, 0);
    check("rst_instr_pc", 32'(bus.instr_pc), 0);
    check("rst_fetch_err", 32'(bus.fetch_err), 0);

    // Free-running stream
    rst = 1'b0;
    tick(10);
    check("A_req0", 32'(req_log[0]), 32'h0000);
    check("A_req1", 32'(req_log[1]), 32'h0004);
    check("A_req2", 32'(req_log[2]), 32'h0008);
    check("A_dat0", dat_log[0], 32'hDEAD0000);
    check("A_pc0", 32'(pc_log[0]), 32'h0000);
    check("A_dat1", dat_log[1], 32'hDEAD0001);
    check("A_pc1", 32'(pc_log[1]), 32'h0004);
    check("A_latency", 32'(first_vld_cyc - first_req_cyc), 2);

    // Decode stalled: issue stops once 4 words are owed
    do_reset(1'b0);
    tick(10);
    check("B_req_count", 32'(req_log.size()), 4);
    check("B_rom_req_idle", 32'(bus.rom_req), 0);
    check("B_valid_full", 32'(bus.instr_valid), 1);
    check("B_head_data", bus.instr_data, 32'hDEAD0000);
    check("B_head_pc", 32'(bus.instr_pc), 0);
    bus.instr_ready = 1'b1;
    tick(10);
    for (int i = 0; i < 4; i++) check("B_order", dat_log[i], 32'hDEAD0000 + 32'(i));
    check("B_next_req", 32'(req_log[4]), 32'h0010);

    // Redirect while 0x0008 is in flight
    do_reset(1'b1);
    wait_req(15'h0008, 20);
    tick(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 15'h0102;
    tick(1);
    bus.redirect_valid = 1'b0;
    tick(10);
    check("C_pc1", 32'(pc_log[1]), 32'h0004);
    check("C_dat2", dat_log[2], 32'hDEAD0040);
    check("C_pc2", 32'(pc_log[2]), 32'h0100);
    found = 0;
    foreach (dat_log[i]) if (dat_log[i] == 32'hDEAD0002) found++;
    check("C_no_DEAD0002", 32'(found), 0);

    // MBIST takes the ROM with two words buffered
    do_reset(1'b1);
    wait_handshake(15'h0004, 20);
    tick(1);
    bus.instr_ready = 1'b0;
    tick(1);
    bus.mbist_en    = 1'b1;
    bus.instr_ready = 1'b1;
    tick(3);
    check("D_hold_req", 32'(bus.rom_req), 0);
    check("D_hold_valid", 32'(bus.instr_valid), 0);
    tick(3);
    bus.mbist_en = 1'b0;
    idx = req_log.size();
    tick(12);
    check("D_resume_addr", 32'(req_log[idx]), 32'h0008);
    check("D_resume_dat", dat_log[2], 32'hDEAD0002);
    check("D_resume_pc", 32'(pc_log[2]), 32'h0008);

    // Address wrap and a missing ROM response
    do_reset(1'b1);
    tick(5);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 15'h7FF8;
    idx = req_log.size();
    tick(1);
    bus.redirect_valid = 1'b0;
    suppress_addr      = 15'h0004;
    suppress_en        = 1'b1;
    skip_pc            = 15'h0004;
    skip_vld           = 1'b1;
    tick(12);
    check("E_req_7ff8", 32'(req_log[idx]), 32'h7FF8);
    check("E_req_7ffc", 32'(req_log[idx+1]), 32'h7FFC);
    check("E_req_wrap", 32'(req_log[idx+2]), 32'h0000);
    check("E_err_set", 32'(bus.fetch_err), 1);
    tick(10);
    check("E_err_sticky", 32'(bus.fetch_err), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("E_err_cleared", 32'(bus.fetch_err), 0);
    check("E_rst_rom_req", 32'(bus.rom_req), 0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
